switch_ctrl: RTL
================

SWITCH_CTRL -- requirements
Module: switch_ctrl

Interface
REQ-001 Parameter HB_TIMEOUT, default 24'd10_000_000: clocks without a heartbeat edge before a CPU is declared dead.
REQ-002 Parameter GUARD, default 16'd1000: clocks of the post-switch guard window.
REQ-003 Port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port force_swi, input, 1: one-clock command pulse from the command decoder.
REQ-006 Port com_swi, input, 1: requested host, 0=A, 1=B; sampled only when force_swi=1.
REQ-007 Port reset_a_signal / reset_b_signal, input, 1 each: CPU A/B is held in reset.
REQ-008 Port power_on_A / power_on_B, input, 1 each: CPU A/B power is enabled.
REQ-009 Port hb_a / hb_b, input, 1 each: asynchronous heartbeat lines; each toggles periodically.
REQ-010 Port switch, output, 1: current host, 0=CPU A, 1=CPU B; feeds the command decoder's switch input.
REQ-011 Port sw_event, output, 1: one-clock pulse on every change of switch.
REQ-012 Port fault_a / fault_b, output, 1 each: CPU A/B is currently unhealthy.
REQ-013 Port sw_count, output, 8: saturating count of automatic (non-commanded) switches.
REQ-014 Port state, output, 2: current FSM state encoding.

Function
REQ-015 hb_a/hb_b SHALL each pass through a 2-FF synchronizer plus one edge-detect flop; either edge is a heartbeat.
REQ-016 Each CPU has a watchdog counter (24 bits); it clears on a heartbeat or while reset_x_signal=1, otherwise increments and saturates at HB_TIMEOUT.
REQ-017 alive_x=0 iff watchdog_x==HB_TIMEOUT; healthy_x = alive_x & power_on_x & ~reset_x_signal; fault_x = ~healthy_x, registered.
REQ-018 The FSM has four states: ACT_A=2'd0, GRD_B=2'd1, ACT_B=2'd2, GRD_A=2'd3; switch=0 in ACT_A/GRD_A and 1 in ACT_B/GRD_B.
REQ-019 ACT_A SHALL go to GRD_B on force_swi&com_swi, or else on ~healthy_a&healthy_b (automatic switch).
REQ-020 ACT_A SHALL stay on force_swi&~com_swi and when both CPUs are unhealthy; ACT_B is the mirror of ACT_A.
REQ-021 On entry to a guard state, the guard counter SHALL load 0 and increment each clock; at GUARD-1 the FSM moves to the matching ACT state.
REQ-022 During guard, automatic switching is suppressed.
REQ-023 force_swi during guard SHALL latch a pending request (last com_swi wins); it is applied in the first ACT cycle, and ignored if it names the current host.
REQ-024 Simultaneous force_swi and an automatic condition in an ACT state: force_swi wins, and sw_count is not incremented.
REQ-025 sw_event SHALL be high exactly in the clock after switch changes value, registered; latency from trigger to switch is 1 clock.
REQ-026 sw_count SHALL increment only on automatic transitions and saturate at 8'hFF.
REQ-027 GUARD=0 or 1 SHALL behave as a one-cycle guard.

Reset
REQ-028 rst_n low SHALL asynchronously force: state=ACT_A, switch=0, sw_event=0, fault_a=fault_b=0, sw_count=0, watchdogs=0, guard counter=0, pending request cleared, synchronizers=0.
REQ-029 Reset mid-guard or mid-switch SHALL abort to ACT_A with no sw_event pulse after release.

Verification (HB_TIMEOUT=100, GUARD=10)
REQ-030 Reset, both heartbeats toggling every 20 clk -> switch=0, fault_a=fault_b=0, sw_count=0 indefinitely.
REQ-031 force_swi=1, com_swi=1 for one clk in ACT_A -> next clk switch=1, sw_event=1 for one clk, state=GRD_B, then ACT_B 10 clk later, sw_count=0.
REQ-032 Stop hb_a in ACT_A, hb_b alive -> fault_a rises about 100 clk later, next clk switch=1, sw_count=1.
REQ-033 Both heartbeats stopped -> both faults set; switch unchanged; sw_count unchanged.
REQ-034 In GRD_B, force_swi with com_swi=0 at guard clk 3 -> stays GRD_B until guard end, then switch=0 one clk after ACT_B entry.
REQ-035 Assert rst_n=0 at guard clk 5 -> immediately switch=0, state=ACT_A; after release no sw_event pulse.

Source files
------------

// File: rtl/switch_ctrl.sv
// Dual-CPU host selector: heartbeat watchdogs, guarded switchover FSM,
// commanded and automatic failover with event pulse and failover counter.
module switch_ctrl #(
  parameter logic [23:0] HB_TIMEOUT = 24'd10_000_000,
  parameter logic [15:0] GUARD      = 16'd1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       force_swi,
  input  logic       com_swi,
  input  logic       reset_a_signal,
  input  logic       reset_b_signal,
  input  logic       power_on_A,
  input  logic       power_on_B,
  input  logic       hb_a,
  input  logic       hb_b,
  output logic       switch,
  output logic       sw_event,
  output logic       fault_a,
  output logic       fault_b,
  output logic [7:0] sw_count,
  output logic [1:0] state
);

  localparam logic [1:0] ACT_A = 2'd0;
  localparam logic [1:0] GRD_B = 2'd1;
  localparam logic [1:0] ACT_B = 2'd2;
  localparam logic [1:0] GRD_A = 2'd3;

  // GUARD of 0 or 1 both collapse to a single guard cycle
  localparam logic [15:0] G_LAST =
    (GUARD > 16'd1) ? GUARD - 16'd1 : 16'd0;

  logic [2:0]  sa, sb;
  logic        beat_a, beat_b;
  logic [23:0] wd_a, wd_b;
  logic        healthy_a, healthy_b;
  logic [15:0] gcnt;
  logic        pend_v, pend_b;
  logic [1:0]  nxt;
  logic        auto_sw;
  logic        req_v, req_b;
  logic        in_grd, nxt_grd;

  // [0],[1] synchronise, [2] holds the previous level for edge detect
  assign beat_a = sa[1] ^ sa[2];
  assign beat_b = sb[1] ^ sb[2];

  assign healthy_a = (wd_a != HB_TIMEOUT) & power_on_A & ~reset_a_signal;
  assign healthy_b = (wd_b != HB_TIMEOUT) & power_on_B & ~reset_b_signal;

  assign switch  = state[1] ^ state[0];
  assign in_grd  = (state == GRD_A) || (state == GRD_B);
  assign nxt_grd = (nxt == GRD_A) || (nxt == GRD_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa      <= '0;
      sb      <= '0;
      wd_a    <= '0;
      wd_b    <= '0;
      fault_a <= 1'b0;
      fault_b <= 1'b0;
    end else begin
      sa      <= {sa[1:0], hb_a};
      sb      <= {sb[1:0], hb_b};
      fault_a <= ~healthy_a;
      fault_b <= ~healthy_b;
      if (reset_a_signal || beat_a)
        wd_a <= '0;
      else if (wd_a != HB_TIMEOUT)
        wd_a <= wd_a + 24'd1;
      if (reset_b_signal || beat_b)
        wd_b <= '0;
      else if (wd_b != HB_TIMEOUT)
        wd_b <= wd_b + 24'd1;
    end
  end

  // a fresh command in the first ACT cycle overrides a latched one
  assign req_v = force_swi | pend_v;
  assign req_b = force_swi ? com_swi : pend_b;

  always_comb begin
    nxt     = state;
    auto_sw = 1'b0;
    unique case (state)
      ACT_A: begin
        if (req_v) begin
          if (req_b) nxt = GRD_B;
        end else if (fault_a && !fault_b) begin
          nxt     = GRD_B;
          auto_sw = 1'b1;
        end
      end
      ACT_B: begin
        if (req_v) begin
          if (!req_b) nxt = GRD_A;
        end else if (fault_b && !fault_a) begin
          nxt     = GRD_A;
          auto_sw = 1'b1;
        end
      end
      GRD_B: if (gcnt >= G_LAST) nxt = ACT_B;
      GRD_A: if (gcnt >= G_LAST) nxt = ACT_A;
      default: nxt = ACT_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACT_A;
      sw_event <= 1'b0;
      gcnt     <= '0;
      pend_v   <= 1'b0;
      pend_b   <= 1'b0;
      sw_count <= '0;
    end else begin
      state    <= nxt;
      sw_event <= (nxt[1] ^ nxt[0]) != switch;
      if (nxt_grd && in_grd)
        gcnt <= gcnt + 16'd1;
      else
        gcnt <= '0;
      if (in_grd) begin
        if (force_swi) begin
          pend_v <= 1'b1;
          pend_b <= com_swi;
        end
      end else begin
        pend_v <= 1'b0;
      end
      if (auto_sw && sw_count != 8'hFF)
        sw_count <= sw_count + 8'd1;
    end
  end

endmodule
